// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: source-record / UART-handshake bundle for tx_arbiter
//   tx_addr_in/tx_buysell_in/tx_timestamp_in/tx_dv_in: per-source records, source i at slice i
//   tx_addr/tx_buysell/tx_timestamp/tx_dv/tx_src: granted record and launch strobe to the UART
//   tx_busy: UART busy; fifo_full/overflow: per-source status; ovf_clr: clears overflow
interface tx_arbiter_if #(parameter int N_SRC = 4);
  logic [8*N_SRC-1:0]  tx_addr_in;
  logic [8*N_SRC-1:0]  tx_buysell_in;
  logic [32*N_SRC-1:0] tx_timestamp_in;
  logic [N_SRC-1:0]    tx_dv_in;
  logic [7:0]          tx_addr;
  logic [7:0]          tx_buysell;
  logic [31:0]         tx_timestamp;
  logic                tx_dv;
  logic                tx_busy;
  logic [2:0]          tx_src;
  logic [N_SRC-1:0]    fifo_full;
  logic [N_SRC-1:0]    overflow;
  logic                ovf_clr;
  modport master (
    input  tx_addr_in, tx_buysell_in, tx_timestamp_in, tx_dv_in, tx_busy, ovf_clr,
    output tx_addr, tx_buysell, tx_timestamp, tx_dv, tx_src, fifo_full, overflow
  );
  modport slave (
    output tx_addr_in, tx_buysell_in, tx_timestamp_in, tx_dv_in, tx_busy, ovf_clr,
    input  tx_addr, tx_buysell, tx_timestamp, tx_dv, tx_src, fifo_full, overflow
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler draining N_SRC order-record FIFOs into one UART tx path
//   clk, reset: clock and asynchronous active-high reset
//   bus (tx_arbiter_if.master): source records in, granted record + tx_dv/tx_src out,
//   tx_busy handshake in, fifo_full/overflow status out, ovf_clr in
//   TX_ARB_PRIO0_EN: when defined, source 0 has strict priority over the round-robin
module tx_arbiter #(
  parameter int N_SRC      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input logic          clk,
  input logic          reset,
  tx_arbiter_if.master bus
);
  localparam int CW = PTR_W + 1;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [47:0] mem_q [N_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [N_SRC];
  logic [PTR_W-1:0] rd_ptr_q [N_SRC];
  logic [CW-1:0] cnt_q [N_SRC];
  logic [N_SRC-1:0] ovf_q, nempty, full, push, pop;
  logic [2:0] last_q, last_d, src_q, src_d, g, g_hi, g_lo;
  logic hi_v, grant, dv_q, dv_d;
  logic [47:0] rec_q, rec_d, head;
  // Round-robin: lowest non-empty index above last_q, else wrap to lowest non-empty overall
  always_comb begin
    nempty = '0;
    full = '0;
    push = '0;
    g_hi = '0;
    g_lo = '0;
    hi_v = 1'b0;
    head = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      nempty[i] = cnt_q[i] != '0;
      full[i] = cnt_q[i] == CW'(FIFO_DEPTH);
      g_lo = nempty[i] ? 3'(i) : g_lo;
      if (nempty[i] && 3'(i) > last_q) begin
        g_hi = 3'(i);
        hi_v = 1'b1;
      end
    end
`ifdef TX_ARB_PRIO0_EN
    g = nempty[0] ? 3'd0 : hi_v ? g_hi : g_lo;
`else
    g = hi_v ? g_hi : g_lo;
`endif
    grant = state_q == IDLE && !bus.tx_busy && nempty != '0;
    pop = grant ? N_SRC'(1) << g : '0;
    // A pop frees a slot on the same edge, so a write into a full FIFO being drained is kept
    for (int i = 0; i < N_SRC; i++) begin
      push[i] = bus.tx_dv_in[i] && (!full[i] || pop[i]);
      if (3'(i) == g) head = mem_q[i][rd_ptr_q[i]];
    end
  end
  always_comb begin
    state_d = state_q;
    dv_d = 1'b0;
    src_d = src_q;
    rec_d = rec_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = WAIT_ACK;
        dv_d = 1'b1;
        src_d = g;
        rec_d = head;
`ifdef TX_ARB_PRIO0_EN
        last_d = g != 3'd0 ? g : last_q;
`else
        last_d = g;
`endif
      end
      WAIT_ACK: state_d = bus.tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      dv_q <= 1'b0;
      src_q <= '0;
      rec_q <= '0;
      last_q <= 3'(N_SRC - 1);
      ovf_q <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dv_q <= dv_d;
      src_q <= src_d;
      rec_q <= rec_d;
      last_q <= last_d;
      ovf_q <= (ovf_q & ~{N_SRC{bus.ovf_clr}}) | (bus.tx_dv_in & ~push);
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(push[i]);
        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(pop[i]);
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < N_SRC; i++)
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= {bus.tx_addr_in[8*i +: 8], bus.tx_buysell_in[8*i +: 8], bus.tx_timestamp_in[32*i +: 32]};
  assign bus.tx_addr = rec_q[47:40];
  assign bus.tx_buysell = rec_q[39:32];
  assign bus.tx_timestamp = rec_q[31:0];
  assign bus.tx_dv = dv_q;
  assign bus.tx_src = src_q;
  assign bus.fifo_full = full;
  assign bus.overflow = ovf_q;
endmodule
